// File: rtl/dlx_imem_loader_if.sv
// Field-bundle handshake and instruction-memory write bus between a program
// source (master) and the DLX instruction-memory loader (slave).
interface dlx_imem_loader_if #(
  parameter int AW = 8
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_opcode;
  logic [5:0]    in_funct;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          in_last;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  modport master (
    output start, in_valid, in_opcode, in_funct, in_rs, in_rt, in_rd,
           in_imm, in_target, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, count
  );

  modport slave (
    input  start, in_valid, in_opcode, in_funct, in_rs, in_rt, in_rd,
           in_imm, in_target, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, count
  );
endinterface

// File: rtl/dlx_imem_loader.sv
// Packs decoded DLX instruction fields into 32-bit words and writes them to
// consecutive instruction-memory addresses, rejecting undecodable opcodes.
module dlx_imem_loader #(
  parameter int            AW   = 8,
  parameter logic [AW-1:0] BASE = '0
) (
  input logic               clk,
  input logic               rst,
  dlx_imem_loader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  localparam logic [AW-1:0] ADDR_MAX = '1;

  state_t        state;
  logic [AW-1:0] addr_q;   // next address to hand out
  logic          stop_q;   // last, illegal or final-address bundle taken
  logic          last_q;   // the word in flight carries in_last
  logic          legal;
  logic [31:0]   word;
  logic          accept;

  // Opcode set mirrors exactly what the ID-stage control decoder accepts.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    legal = 1'b0;
    word  = '0;
    case (bus.in_opcode) inside
      6'h00, 6'h01: begin
        legal = 1'b1;
        word  = {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, bus.in_funct};
      end
      6'h02, 6'h03: begin
        legal = 1'b1;
        word  = {bus.in_opcode, bus.in_target};
      end
      6'h12, 6'h13: begin
        legal = 1'b1;
        word  = {bus.in_opcode, bus.in_rs, 21'b0};
      end
      6'h04, 6'h05, [6'h08:6'h0F], 6'h14, [6'h16:6'h1D], 6'h20, 6'h21,
      [6'h23:6'h25], 6'h28, 6'h29, 6'h2B: begin
        legal = 1'b1;
        word  = {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_imm};
      end
      default: ;
    endcase
  end

  assign bus.in_ready = (state == LOAD) && !stop_q;
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= BASE;
      stop_q        <= 1'b0;
      last_q        <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.count     <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            state        <= LOAD;
            bus.busy     <= 1'b1;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            addr_q       <= BASE;
            bus.mem_addr <= BASE;
            bus.count    <= '0;
            stop_q       <= 1'b0;
            last_q       <= 1'b0;
          end
        end
        LOAD: begin
          // Completion of the write issued on the previous edge.
          if (bus.mem_we) begin
            bus.count <= bus.count + 1'b1;
            if (last_q) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else if (bus.mem_addr == ADDR_MAX) begin
              state    <= ERR;
              bus.busy <= 1'b0;
              bus.err  <= 1'b1;
            end
          end
          if (accept) begin
            bus.mem_addr <= addr_q;
            stop_q       <= bus.in_last || !legal || (addr_q == ADDR_MAX);
            if (legal) begin
              bus.mem_we    <= 1'b1;
              bus.mem_wdata <= word;
              last_q        <= bus.in_last;
              if (addr_q != ADDR_MAX) addr_q <= addr_q + 1'b1;
            end else begin
              state    <= ERR;
              bus.busy <= 1'b0;
              bus.err  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_imem_loader.sv
// Scoreboard bench for dlx_imem_loader: a wide instance (AW=8) for encoding,
// streaming, illegal-opcode and reset scenarios, a narrow one (AW=2) for overflow.
module tb_dlx_imem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [5:0]  in_opcode = '0, in_funct = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;

  dlx_imem_loader_if #(.AW(8)) bus_l ();
  dlx_imem_loader_if #(.AW(2)) bus_s ();

  dlx_imem_loader #(.AW(8), .BASE(8'h00)) dut   (.clk(clk), .rst(rst), .bus(bus_l.slave));
  dlx_imem_loader #(.AW(2), .BASE(2'b00)) dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));

  assign bus_l.start    = start & ~sel;
  assign bus_s.start    = start & sel;
  assign bus_l.in_valid = in_valid & ~sel;
  assign bus_s.in_valid = in_valid & sel;
  assign {bus_l.in_opcode, bus_l.in_funct, bus_l.in_rs, bus_l.in_rt, bus_l.in_rd,
          bus_l.in_imm, bus_l.in_target, bus_l.in_last} =
         {in_opcode, in_funct, in_rs, in_rt, in_rd, in_imm, in_target, in_last};
  assign {bus_s.in_opcode, bus_s.in_funct, bus_s.in_rs, bus_s.in_rt, bus_s.in_rd,
          bus_s.in_imm, bus_s.in_target, bus_s.in_last} =
         {in_opcode, in_funct, in_rs, in_rt, in_rd, in_imm, in_target, in_last};

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  wr_t         q_l[$];
  wr_t         q_s[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_addr = 0;

  // Every observed write must match the oldest expected one.
  always @(negedge clk) begin
    wr_t e;
    if (bus_l.mem_we) begin
      checks++;
      if (q_l.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write_l addr=%0d data=%h", bus_l.mem_addr, bus_l.mem_wdata);
      end else begin
        e = q_l.pop_front();
        if (bus_l.mem_addr !== 8'(e.addr) || bus_l.mem_wdata !== e.data) begin
          errors++;
          $display("FAIL write_l got addr=%0d data=%h exp addr=%0d data=%h",
                   bus_l.mem_addr, bus_l.mem_wdata, e.addr, e.data);
        end
      end
    end
    if (bus_s.mem_we) begin
      checks++;
      if (q_s.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write_s addr=%0d data=%h", bus_s.mem_addr, bus_s.mem_wdata);
      end else begin
        e = q_s.pop_front();
        if (bus_s.mem_addr !== 2'(e.addr) || bus_s.mem_wdata !== e.data) begin
          errors++;
          $display("FAIL write_s got addr=%0d data=%h exp addr=%0d data=%h",
                   bus_s.mem_addr, bus_s.mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  // {busy, done, err, in_ready, count[8:0], mem_addr[7:0]} of the selected DUT.
  function automatic logic [20:0] status();
    if (sel)
      return {bus_s.busy, bus_s.done, bus_s.err, bus_s.in_ready, 6'b0, bus_s.count,
              6'b0, bus_s.mem_addr};
    return {bus_l.busy, bus_l.done, bus_l.err, bus_l.in_ready, bus_l.count, bus_l.mem_addr};
  endfunction

  function automatic logic [20:0] mk(bit b, bit d, bit e, bit r, int c, int a);
    return {b, d, e, r, 9'(c), 8'(a)};
  endfunction

  function automatic logic ready();
    return sel ? bus_s.in_ready : bus_l.in_ready;
  endfunction

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    exp_addr = 0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Presents one bundle; returns 1 ns after the accepting edge, or after a
  // bounded wait when no accept occurs.
  task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                      input logic [25:0] tgt, input bit last, input logic [31:0] word,
                      input bit legal, input bit want_accept);
    bit acc = 1'b0;
    in_opcode = op; in_funct = fn; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready()) begin
        acc = 1'b1;
        break;
      end
    end
    if (acc && legal) begin
      if (sel) q_s.push_back('{addr: exp_addr, data: word});
      else     q_l.push_back('{addr: exp_addr, data: word});
      exp_addr++;
    end
    if (acc) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (acc != want_accept) begin
      errors++;
      $display("FAIL accept op=%h got=%0d exp=%0d", op, acc, want_accept);
    end
  endtask

  task automatic test_reset();
    logic [20:0] o;
    wait_neg(2);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      o = status();
      checks++;
      if (o !== mk(0, 0, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL reset_status sel=%0d got=%h exp=%h", s, o, mk(0, 0, 0, 0, 0, 0));
      end
    end
    checks++;
    if ({bus_l.mem_we, bus_l.mem_wdata, bus_s.mem_we, bus_s.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem got we=%b data=%h", bus_l.mem_we, bus_l.mem_wdata);
    end
    sel = 1'b0;
    #1 rst = 1'b0;
  endtask

  task automatic test_addi();
    logic [20:0] o;
    sel = 1'b0;
    do_start();
    o = status();
    checks++;
    if (o !== mk(1, 0, 0, 1, 0, 0)) begin
      errors++; $display("FAIL addi_start got=%h exp=%h", o, mk(1, 0, 0, 1, 0, 0));
    end
    send(6'h08, 6'h00, 5'd2, 5'd1, 5'd0, 16'h0005, 26'h0, 1'b1, 32'h20410005, 1'b1, 1'b1);
    wait_neg(2);
    o = status();
    checks++;
    if (o !== mk(0, 1, 0, 0, 1, 0)) begin
      errors++; $display("FAIL addi_done got=%h exp=%h", o, mk(0, 1, 0, 0, 1, 0));
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] o;
    sel = 1'b0;
    do_start();
    send(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0, 1'b0, 32'h00221820, 1'b1, 1'b1);
    send(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h10, 1'b1, 32'h08000010, 1'b1, 1'b1);
    o = status();
    checks++;
    if (o !== mk(1, 0, 0, 0, 1, 1)) begin
      errors++; $display("FAIL b2b_last_write got=%h exp=%h", o, mk(1, 0, 0, 0, 1, 1));
    end
    wait_neg(2);
    o = status();
    checks++;
    if (o !== mk(0, 1, 0, 0, 2, 1)) begin
      errors++; $display("FAIL b2b_done got=%h exp=%h", o, mk(0, 1, 0, 0, 2, 1));
    end
  endtask

  // Unused fields carry junk to show they are ignored per class.
  task automatic test_encodings();
    logic [20:0] o;
    sel = 1'b0;
    do_start();
    send(6'h12, 6'h15, 5'd31, 5'd7, 5'd9, 16'hABCD, 26'h155, 1'b0, 32'h4BE00000, 1'b1, 1'b1);
    send(6'h23, 6'h3F, 5'd0, 5'd4, 5'd31, 16'hFFFC, 26'h3FF, 1'b0, 32'h8C04FFFC, 1'b1, 1'b1);
    send(6'h2B, 6'h01, 5'd3, 5'd5, 5'd2, 16'h0010, 26'h1, 1'b0, 32'hAC650010, 1'b1, 1'b1);
    send(6'h03, 6'h07, 5'd5, 5'd6, 5'd7, 16'h1111, 26'h3FFFFFF, 1'b0, 32'h0FFFFFFF, 1'b1, 1'b1);
    send(6'h01, 6'h0E, 5'd5, 5'd6, 5'd7, 16'hFFFF, 26'h0, 1'b0, 32'h04A6380E, 1'b1, 1'b1);
    send(6'h14, 6'h2A, 5'd0, 5'd0, 5'd3, 16'h1234, 26'h5, 1'b1, 32'h50001234, 1'b1, 1'b1);
    wait_neg(2);
    o = status();
    checks++;
    if (o !== mk(0, 1, 0, 0, 6, 5)) begin
      errors++; $display("FAIL enc_done got=%h exp=%h", o, mk(0, 1, 0, 0, 6, 5));
    end
  endtask

  task automatic test_illegal();
    logic [20:0] o;
    sel = 1'b0;
    do_start();
    send(6'h08, 6'h00, 5'd2, 5'd1, 5'd0, 16'h0005, 26'h0, 1'b0, 32'h20410005, 1'b1, 1'b1);
    send(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0, 1'b0, 32'h00221820, 1'b1, 1'b1);
    send(6'h3F, 6'h00, 5'd1, 5'd1, 5'd1, 16'h0001, 26'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    o = status();
    checks++;
    if (o !== mk(0, 0, 1, 0, 2, 2) || bus_l.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL illegal_err got=%h we=%b exp=%h", o, bus_l.mem_we, mk(0, 0, 1, 0, 2, 2));
    end
    send(6'h08, 6'h00, 5'd2, 5'd1, 5'd0, 16'h0007, 26'h0, 1'b1, 32'h20410007, 1'b1, 1'b0);
    do_start();
    o = status();
    checks++;
    if (o !== mk(1, 0, 0, 1, 0, 0)) begin
      errors++; $display("FAIL illegal_restart got=%h exp=%h", o, mk(1, 0, 0, 1, 0, 0));
    end
    send(6'h06, 6'h00, 5'd1, 5'd1, 5'd1, 16'h0001, 26'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    o = status();
    checks++;
    if (o !== mk(0, 0, 1, 0, 0, 0)) begin
      errors++; $display("FAIL illegal_first got=%h exp=%h", o, mk(0, 0, 1, 0, 0, 0));
    end
    do_start();
    send(6'h1D, 6'h00, 5'd1, 5'd2, 5'd0, 16'h0003, 26'h0, 1'b1, 32'h74220003, 1'b1, 1'b1);
    wait_neg(2);
    o = status();
    checks++;
    if (o !== mk(0, 1, 0, 0, 1, 0)) begin
      errors++; $display("FAIL edge_opcode_done got=%h exp=%h", o, mk(0, 1, 0, 0, 1, 0));
    end
  endtask

  task automatic test_overflow();
    logic [20:0] o;
    sel = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++)
      send(6'h08, 6'h00, 5'd2, 5'd1, 5'd0, 16'(i + 1), 26'h0, 1'b0,
           32'h20410000 | 32'(i + 1), 1'b1, 1'b1);
    send(6'h08, 6'h00, 5'd2, 5'd1, 5'd0, 16'h0009, 26'h0, 1'b0, 32'h20410009, 1'b1, 1'b0);
    o = status();
    checks++;
    if (o !== mk(0, 0, 1, 0, 4, 3)) begin
      errors++; $display("FAIL overflow got=%h exp=%h", o, mk(0, 0, 1, 0, 4, 3));
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [20:0] o;
    sel = 1'b0;
    do_start();
    send(6'h08, 6'h00, 5'd2, 5'd1, 5'd0, 16'h0005, 26'h0, 1'b0, 32'h20410005, 1'b1, 1'b1);
    in_opcode = 6'h00; in_funct = 6'h20; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
    in_last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    o = status();
    checks++;
    if (o !== mk(0, 0, 0, 0, 0, 0) || bus_l.mem_we !== 1'b0 || bus_l.mem_wdata !== '0) begin
      errors++;
      $display("FAIL rst_mid got=%h we=%b data=%h", o, bus_l.mem_we, bus_l.mem_wdata);
    end
    wait_neg(3);
    in_valid = 1'b0;
    rst = 1'b0;
    do_start();
    send(6'h23, 6'h00, 5'd0, 5'd4, 5'd0, 16'hFFFC, 26'h0, 1'b1, 32'h8C04FFFC, 1'b1, 1'b1);
    wait_neg(2);
    o = status();
    checks++;
    if (o !== mk(0, 1, 0, 0, 1, 0)) begin
      errors++; $display("FAIL rst_reload got=%h exp=%h", o, mk(0, 1, 0, 0, 1, 0));
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_encodings();
    test_illegal();
    test_overflow();
    test_reset_mid();
    wait_neg(2);
    checks++;
    if (q_l.size() != 0 || q_s.size() != 0) begin
      errors++;
      $display("FAIL missing_writes got=%0d,%0d exp=0,0", q_l.size(), q_s.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dlx_imem_loader.md
# dlx_imem_loader

Sequential instruction encoder and instruction-memory loader for the pipelined DLX core: the producing end of the opcode/funct decode path. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit DLX words using the exact opcode set the ID-stage control decoder recognises. Each word is written to consecutive instruction-memory addresses. It runs before the core is released from stall and rejects any opcode the control decoder cannot decode.

## Interface
- AW, 8: instruction-memory address width in words.
- BASE, 0: first write address (AW bits).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader accepts a bundle this cycle.
- in_opcode  in  6  DLX opcode.
- in_funct  in  6  R-type function code; ignored for other classes.
- in_rs  in  5  rs1 field.
- in_rt  in  5  second register field: R-type rs2, I-type destination or store source.
- in_rd  in  5  R-type destination.
- in_imm  in  16  I-type immediate.
- in_target  in  26  J-type offset.
- in_last  in  1  marks the final bundle of the program.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  AW  write address.
- mem_wdata  out  32  encoded word.
- busy  out  1  high in LOAD.
- done  out  1  high in DONE.
- err  out  1  high in ERR.
- count  out  AW+1  words written this session.

## Operation
- States: IDLE, LOAD, DONE, ERR. Reset enters IDLE with these values: all outputs 0, address register = BASE, count = 0, pending register empty.
- IDLE, DONE or ERR with start=1 moves to LOAD next cycle. On this transition the address register is set to BASE, count to 0, and the pending register is cleared. start is ignored while in LOAD.
- LOAD: in_ready = 1 unless a bundle flagged in_last or an illegal bundle has already been accepted. A bundle is accepted when in_valid && in_ready.
- Instruction classes and encodings:
  - R (0x00, 0x01): {opcode, rs, rt, rd, 5'b0, funct}.
  - J (0x02 J, 0x03 JAL): {opcode, target}.
  - JR-class (0x12, 0x13): {opcode, rs, 21'b0}.
  - All other legal opcodes are I-type: {opcode, rs, rt, imm}.
- Legal opcodes: 00–05, 08–0F, 12, 13, 14, 16–1D, 20, 21, 23, 24, 25, 28, 29, 2B. Every other opcode is illegal.
- Legal accepted bundle: the encoded word is registered and written on the following cycle at the current address. After the write, the address and count increment by 1.
- Illegal accepted bundle: no write occurs. The loader enters ERR next cycle, and mem_addr holds the address that would have been written.
- Overflow: if a write lands at address 2^AW−1 and in_last was not set, the loader enters ERR after that write. The address never wraps.
- When the write of the in_last word completes, the loader enters DONE. done and err hold until the next start.

## Timing
- Latency: bundle accepted at edge N → mem_we=1 with its address and data during cycle N+1 (the cycle after edge N).
- Throughput: one word per cycle; back-to-back accepts are legal. Memory never back-pressures.
- in_ready is combinational from state and flags, with no dependence on in_valid.
- State transitions to DONE and ERR take effect at the edge that ends the final write cycle (or the illegal-accept cycle). busy drops at that same edge.
- Asserting rst mid-LOAD aborts the session immediately (asynchronous). No mem_we pulse is issued after rst rises, and the session restarts only on a new start.
- Outputs are registered, except in_ready.

## Test plan
- ADDI: opcode 0x08, rs 2, rt 1, imm 0x0005 → mem_wdata 0x20410005 at address BASE one cycle after accept; count=1.
- Streaming R then J: R-type ADD (funct 0x20, rs 1, rt 2, rd 3), then J (target 0x10) with last=1, valid both cycles → 0x00221820 at address 0, then 0x08000010 at address 1 on consecutive cycles; done=1 next cycle; count=2.
- JR: opcode 0x12, rs 31, with non-zero rt/imm → 0x4BE00000 (rt/imm ignored); LW opcode 0x23, rs 0, rt 4, imm 0xFFFC → 0x8C04FFFC.
- Illegal opcode 0x3F mid-stream after two words → no write for it; err=1; in_ready=0; mem_addr=2; new start → LOAD with err=0 and address=BASE.
- Overflow with AW=2: five legal bundles, none flagged last → four writes at addresses 0–3, then err=1; the fifth bundle is never accepted.
- Reset during streaming: rst asserted between accepts → all outputs 0 immediately, no further mem_we; a subsequent start reloads from BASE correctly.
